hex_display_ctrl: RTL and testbench
===================================

# hex_display_ctrl

Registered, parametrised multi-digit hexadecimal display controller for active-low 7-segment displays. It is the successor to the two-digit combinational hex decoder and keeps that decoder's rule that a zero value blanks the display. On top of that it adds a load-strobed value register, leading-zero suppression, and a per-digit blink engine driven by a free-running divider. It sits between datapath results and the board HEX displays.

## Interface
Parameters:
- `DIGITS`, default 2: number of hex digits driven (1..8).
- `BLINK_DIV`, default 25_000_000: clock cycles per blink half-period (≥2).
- `ZERO_BLANK`, default 1: when 1, a latched value of 0 blanks every digit.

Ports:
- `clk`  in  1  : the single clock; all state updates on the rising edge.
- `clrn`  in  1  : reset, asynchronous and active-low.
- `load`  in  1  : when 1 at a clock edge, `din` is latched.
- `din`  in  4*DIGITS  : value to display; nibble i drives digit i, with digit 0 least significant.
- `lzb_en`  in  1  : leading-zero suppression enable.
- `blink_en`  in  1  : blink engine enable.
- `blink_mask`  in  DIGITS  : bit i = 1 makes digit i blink.
- `seg`  out  7*DIGITS  : active-low segments; `seg[7i+6:7i]` is digit i, bit order {g,f,e,d,c,b,a}.
- `blank_phase`  out  1  : current blink phase; 1 means the masked digits are dark.

## Operation
- State:
  - value register `val_q`, width 4*DIGITS;
  - divider `cnt`, range 0..BLINK_DIV-1, width $clog2(BLINK_DIV);
  - phase flop `phase`.
- Load: at an edge with `load`=1, `val_q <= din`. Otherwise `val_q` holds.
- Glyphs (active-low, {g..a}), for 0–F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110. A blank digit is 1111111.
- Per-digit blank decision. Digit i is blank if any of these holds:
  - ZERO_BLANK=1 and `val_q`==0;
  - `lzb_en`=1, i>0, and every nibble j≥i of `val_q` is 0;
  - `blink_en`=1, `blink_mask[i]`=1, and `phase`=1.
- When none of the conditions holds, digit i shows the glyph of nibble i.
- Leading-zero suppression never blanks digit 0. With ZERO_BLANK=0 and `lzb_en`=1, a value of 0 shows a single "0".
- Blink engine:
  - while `blink_en`=1, `cnt` increments each cycle;
  - when `cnt`==BLINK_DIV-1, `cnt` wraps to 0 and `phase` toggles;
  - while `blink_en`=0, `cnt` <= 0 and `phase` <= 0 (synchronous clear).
- `blank_phase` = `phase`.
- `seg` is a combinational function of `val_q`, `phase`, `lzb_en`, `blink_en` and `blink_mask`, with no extra register stage.

## Timing
- Reset (`clrn`=0, asynchronous): `val_q`=0, `cnt`=0, `phase`=0, `blank_phase`=0.
  - With ZERO_BLANK=1, `seg` = all ones.
  - With ZERO_BLANK=0, `seg` shows zeros (or only digit 0 when `lzb_en`=1).
- Reset removal is synchronised externally. The first active edge after deassertion behaves normally.
- Load latency: `seg` reflects `din` immediately after the edge that samples `load`=1. Changes on `din` without `load` have no effect.
- Mode inputs (`lzb_en`, `blink_mask`) act combinationally in the same cycle.
- `blink_en` rising: the first phase toggle occurs BLINK_DIV edges after the first edge sampling `blink_en`=1. After that, `phase` toggles every BLINK_DIV cycles, giving a period of 2*BLINK_DIV.
- `blink_en` falling: masked digits reappear combinationally in the same cycle. `phase` and `cnt` clear at the next edge.
- Simultaneous load and phase toggle: both take effect at the same edge. Loading does not disturb the divider.
- Reset asserted mid-blink clears `phase` immediately, so all blink-blanked digits reappear subject to the other rules.

## Test plan
(DIGITS=4, BLINK_DIV=4 unless stated.)
- Reset: hold `clrn`=0 -> `seg`=28'hFFFFFFF, `blank_phase`=0. Release, then load 16'h0000 -> `seg` stays all ones.
- Glyph sweep: load 16'h0123, then 16'h4567, 16'h89AB, 16'hCDEF, with `lzb_en`=0 -> every digit matches the table in the cycle after each load. `din` changed without `load` -> `seg` unchanged.
- Leading-zero suppression: load 16'h0040 with `lzb_en`=1 -> digits 3 and 2 are 1111111, digit 1 = 0011001, digit 0 = 1000000.
- ZERO_BLANK=0 with `lzb_en`=1, load 0 -> only digit 0 lit, showing 1000000.
- Blink timing: load 16'h1234, `blink_mask`=4'b0011, `blink_en`=1 -> `blank_phase` rises 4 cycles later. Digits 1 and 0 are then blank while digits 3 and 2 stay lit, and the pattern toggles every 4 cycles. Drop `blink_en` -> digits reappear the same cycle and `phase`=0 after one edge.
- Mid-operation reset: assert `clrn` while `phase`=1 and `val_q`=16'h1234 -> `seg` all ones immediately. After release `cnt`=0, and a reload of 16'h1234 restarts blinking from a full half-period.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display controller for active-low 7-segment digits:
// a load-strobed value register, zero blanking, leading-zero suppression and a per-digit blink engine.
module hex_display_ctrl #(
  parameter int DIGITS     = 2,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int ZERO_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  lzb_en,
  input  logic                  blink_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  blank_phase
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_DARK = 7'h7F;

  logic [4*DIGITS-1:0] val_r;
  logic [CW-1:0]       cnt_r;
  logic                phase_r;
  logic [7*DIGITS-1:0] seg_s;

  // Active-low glyph for one nibble, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0011000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      4'hF:    g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Displayed value register, updated only on a load strobe.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      val_r <= '0;
    end else if (load) begin
      val_r <= din;
    end else begin
      val_r <= val_r;
    end
  end

  // Blink divider and phase; disabling the engine clears both so a re-enable starts a full half-period.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (!blink_en) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1'b1);
      phase_r <= phase_r;
    end
  end

  // Per-digit blank decision and glyph selection; digit 0 is never removed by leading-zero suppression.
  always_comb begin
    seg_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      logic upper_zero;
      logic blank;
      upper_zero = 1'b1;
      for (int j = i; j < DIGITS; j++) begin
        if (val_r[4*j +: 4] != 4'h0) begin
          upper_zero = 1'b0;
        end else begin
          upper_zero = upper_zero;
        end
      end
      blank = ((ZERO_BLANK != 0) && (val_r == '0))
            || (lzb_en && (i != 0) && upper_zero)
            || (blink_en && blink_mask[i] && phase_r);
      if (blank) begin
        seg_s[7*i +: 7] = SEG_DARK;
      end else begin
        seg_s[7*i +: 7] = glyph(val_r[4*i +: 4]);
      end
    end
  end

  assign seg         = seg_s;
  assign blank_phase = phase_r;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench: one ZERO_BLANK=1 and one ZERO_BLANK=0 instance on shared inputs, checked
// every cycle against a value/edge-count model, plus hand-computed literal expectations.
module tb_hex_display_ctrl;

  localparam int D   = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   din = 16'h0000;
  logic          lzb_en = 1'b0;
  logic          blink_en = 1'b0;
  logic [3:0]    blink_mask = 4'b0000;
  logic [27:0]   seg_zb1, seg_zb0;
  logic          bp_zb1, bp_zb0;

  int compared = 0;
  int mismatched = 0;

  // Model state: latched value and number of consecutive edges sampled with blink_en=1.
  logic [15:0] mv = 16'h0000;
  int          bc = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_ctrl #(.DIGITS(D), .BLINK_DIV(DIV), .ZERO_BLANK(1)) dut_zb1 (
    .clk(clk), .clrn(clrn), .load(load), .din(din), .lzb_en(lzb_en), .blink_en(blink_en),
    .blink_mask(blink_mask), .seg(seg_zb1), .blank_phase(bp_zb1));

  hex_display_ctrl #(.DIGITS(D), .BLINK_DIV(DIV), .ZERO_BLANK(0)) dut_zb0 (
    .clk(clk), .clrn(clrn), .load(load), .din(din), .lzb_en(lzb_en), .blink_en(blink_en),
    .blink_mask(blink_mask), .seg(seg_zb0), .blank_phase(bp_zb0));

  always #5 clk = ~clk;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mv = 16'h0000;
      bc = 0;
    end else begin
      if (load) mv = din;
      if (blink_en) bc = bc + 1;
      else bc = 0;
    end
  end

  function automatic logic model_phase();
    return ((bc / DIV) % 2) == 1;
  endfunction

  function automatic logic [27:0] exp_seg(input logic zb);
    logic [27:0] r;
    logic        blank;
    r = 28'h0;
    for (int i = 0; i < D; i++) begin
      blank = (zb && mv == 16'h0000)
           || (lzb_en && i > 0 && (mv >> (4 * i)) == 16'h0000)
           || (blink_en && blink_mask[i] && model_phase());
      r[7*i +: 7] = blank ? 7'h7F : glyph_tab[mv[4*i +: 4]];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_seg_zb1", seg_zb1, exp_seg(1'b1));
    check("model_seg_zb0", seg_zb0, exp_seg(1'b0));
    check("model_phase", {27'h0, bp_zb1}, {27'h0, model_phase()});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [15:0] v);
    din  = v;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    tick(2);
    check("reset_seg_zb1", seg_zb1, 28'hFFFFFFF);
    check("reset_seg_zb0", seg_zb0, {7'h40, 7'h40, 7'h40, 7'h40});
    check("reset_phase", {27'h0, bp_zb1}, 28'h0);
    clrn = 1'b1;
    do_load(16'h0000);
    check("load_zero_blank", seg_zb1, 28'hFFFFFFF);

    // Glyph sweep.
    do_load(16'h0123);
    check("glyph_0123", seg_zb1, {7'h40, 7'h79, 7'h24, 7'h30});
    do_load(16'h4567);
    do_load(16'h89AB);
    do_load(16'hCDEF);
    check("glyph_cdef", seg_zb1, {7'h46, 7'h21, 7'h06, 7'h0E});
    din = 16'hFFFF;
    tick(2);
    check("din_no_load", seg_zb1, {7'h46, 7'h21, 7'h06, 7'h0E});

    // Leading-zero suppression.
    lzb_en = 1'b1;
    do_load(16'h0040);
    check("lzb_0040", seg_zb1, {7'h7F, 7'h7F, 7'h19, 7'h40});
    do_load(16'h0000);
    check("lzb_zero_zb0", seg_zb0, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    check("lzb_zero_zb1", seg_zb1, 28'hFFFFFFF);
    lzb_en = 1'b0;

    // Blink timing.
    do_load(16'h1234);
    check("lit_1234", seg_zb1, {7'h79, 7'h24, 7'h30, 7'h19});
    blink_mask = 4'b0011;
    blink_en   = 1'b1;
    tick(3);
    check("blink_pre_toggle", {27'h0, bp_zb1}, 28'h0);
    tick(1);
    check("blink_first_toggle", {27'h0, bp_zb1}, 28'h1);
    check("blink_dark_digits", seg_zb1, {7'h79, 7'h24, 7'h7F, 7'h7F});
    tick(4);
    check("blink_second_toggle", {27'h0, bp_zb1}, 28'h0);
    tick(4);
    check("blink_third_toggle", {27'h0, bp_zb1}, 28'h1);
    blink_en = 1'b0;
    #1;
    check("blink_off_comb", seg_zb1, {7'h79, 7'h24, 7'h30, 7'h19});
    tick(1);
    check("blink_off_phase", {27'h0, bp_zb1}, 28'h0);

    // Mid-operation reset while phase is high.
    blink_en = 1'b1;
    tick(4);
    check("pre_reset_phase", {27'h0, bp_zb1}, 28'h1);
    clrn = 1'b0;
    #1;
    check("mid_reset_seg", seg_zb1, 28'hFFFFFFF);
    check("mid_reset_phase", {27'h0, bp_zb1}, 28'h0);
    tick(1);
    clrn = 1'b1;
    do_load(16'h1234);
    tick(2);
    check("restart_pre_toggle", {27'h0, bp_zb1}, 28'h0);
    tick(1);
    check("restart_toggle", {27'h0, bp_zb1}, 28'h1);
    check("restart_dark", seg_zb1, {7'h79, 7'h24, 7'h7F, 7'h7F});

    // Load coinciding with a phase toggle leaves the divider untouched.
    tick(3);
    do_load(16'h00A5);
    check("load_at_toggle_phase", {27'h0, bp_zb1}, 28'h0);
    check("load_at_toggle_seg", seg_zb1, {7'h40, 7'h40, 7'h08, 7'h12});
    blink_en = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
